// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Sequences every main-memory transaction (MAR load, MEM_EN/RW
//               drive, MFC wait, read-data capture) and shares the single
//               memory port between two requesters with round-robin grants.
//                 requester 0 : instruction fetch (ID/PC path)
//                 requester 1 : data load/store  (ID/MDR path)
//               A bounded MFC wait aborts a transaction when memory hangs.
// Ports       :
//   clk        in   1         system clock, all state on rising edge
//   reset      in   1         asynchronous active-high reset
//   req        in   2         per-requester request, held until its ack
//   rw         in   2         per-requester direction, 1=read 0=write
//   addr       in   2*ADDR_W  packed requester addresses (i*ADDR_W +: ADDR_W)
//   wdata      in   2*DATA_W  packed requester write data
//   ack        out  2         one-cycle completion pulse per requester
//   err        out  1         with ack: transaction aborted by timeout
//   rdata      out  DATA_W    captured read data, valid while ack is high
//   mar_out    out  ADDR_W    memory address
//   mem_en     out  1         memory enable (high only while waiting for MFC)
//   mem_rw     out  1         memory read/write select
//   mem_wdata  out  DATA_W    memory write data
//   mem_rdata  in   DATA_W    memory read data
//   mfc        in   1         memory function complete, level
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15      // legal range 1..255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req,
    input  logic [1:0]           rw,
    input  logic [2*ADDR_W-1:0]  addr,
    input  logic [2*DATA_W-1:0]  wdata,
    output logic [1:0]           ack,
    output logic                 err,
    output logic [DATA_W-1:0]    rdata,
    output logic [ADDR_W-1:0]    mar_out,
    output logic                 mem_en,
    output logic                 mem_rw,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mfc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Counter value at which the current non-MFC edge is the last one allowed.
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic       r_ptr;          // requester that has priority at the next grant
    logic       r_gnt;          // requester owning the current transaction
    logic       r_timed_out;
    logic [7:0] r_cnt;

    logic       w_any_req;
    logic       w_gnt;

    assign w_any_req = |req;
    // Priority requester wins if it asks, otherwise the other one takes the slot.
    assign w_gnt     = req[r_ptr] ? r_ptr : ~r_ptr;

    // Decoded straight from the state register so an asynchronous reset drops
    // the memory enable immediately and it can never be high outside WAIT.
    assign mem_en = (r_state == S_WAIT);
    assign ack    = (r_state == S_DONE) ? {r_gnt, ~r_gnt} : 2'b00;
    assign err    = (r_state == S_DONE) & r_timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= 1'b0;
            r_gnt       <= 1'b0;
            r_timed_out <= 1'b0;
            r_cnt       <= 8'd0;
            rdata       <= '0;
            mar_out     <= '0;
            mem_rw      <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt     <= w_gnt;
                        mar_out   <= w_gnt ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
                        mem_wdata <= w_gnt ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
                        mem_rw    <= w_gnt ? rw[1] : rw[0];
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt       <= 8'd0;
                    r_timed_out <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    // MFC is tested first so it beats a timeout on the same edge.
                    if (mfc) begin
                        if (mem_rw) begin
                            rdata <= mem_rdata;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == C_TIMEOUT_LAST) begin
                        rdata       <= '0;
                        r_timed_out <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_ptr   <= ~r_gnt;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench for mem_bus_arbiter. Stimulus rounds
//               enqueue the expected outcome of every transaction (computed
//               from round-robin rules and per-transaction memory latency);
//               a memory model answers with MFC, and a monitor pops and
//               compares on every ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int TIMEOUT      = 15;
    localparam int ROUND_BUDGET = 2000;
    localparam int NEVER        = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  rw = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  ack;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] mar_out;
    logic        mem_en;
    logic        mem_rw;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mfc = 1'b0;

    mem_bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .mar_out   (mar_out),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mfc       (mfc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mdata;   // data memory returns for this access
        int          lat;     // WAIT cycle on which memory asserts MFC
    } txn_t;

    typedef struct {
        int          id;
        logic        err;
        logic [15:0] rdata;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          waits;
        int          ack_cyc;
    } exp_t;

    txn_t        pq0[$];
    txn_t        pq1[$];
    exp_t        exp_q[$];
    int          lat_q[$];
    logic [15:0] dat_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          model_ptr = 0;
    logic [15:0] model_rdata = '0;
    bit          hung = 1'b0;

    // memory-model observations of the transaction currently / last on the bus
    logic [15:0] obs_addr = '0;
    logic [15:0] obs_wdata = '0;
    logic        obs_rw = 1'b0;
    int          obs_waits = 0;
    bit          obs_unstable = 1'b0;
    bit          mm_busy = 1'b0;
    int          mm_n = 0;
    int          mm_lat = 0;
    logic [15:0] mm_data = '0;
    bit          mon_prev_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic txn_t mk(input logic r, input logic [15:0] a, input logic [15:0] w,
                                input logic [15:0] d, input int l);
        txn_t t;
        t.rw = r; t.addr = a; t.wdata = w; t.mdata = d; t.lat = l;
        return t;
    endfunction

    function automatic int rand_lat();
        case ($urandom_range(0, 9))
            0:       return TIMEOUT;
            1:       return TIMEOUT + 1;
            2:       return TIMEOUT - 1;
            default: return int'($urandom_range(1, 4));
        endcase
    endfunction

    function automatic txn_t rand_txn();
        return mk(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), rand_lat());
    endfunction

    task automatic load(input int i, input txn_t t);
        if (i == 0) begin
            rw[0] = t.rw; addr[15:0] = t.addr; wdata[15:0] = t.wdata;
        end else begin
            rw[1] = t.rw; addr[31:16] = t.addr; wdata[31:16] = t.wdata;
        end
    endtask

    // Memory: counts WAIT cycles, asserts MFC on the transaction's latency,
    // scribbles random MFC/data whenever the enable is low.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mm_busy = 1'b0;
                mfc     = 1'b0;
            end else if (mem_en) begin
                if (!mm_busy) begin
                    mm_busy      = 1'b1;
                    mm_n         = 0;
                    obs_addr     = mar_out;
                    obs_rw       = mem_rw;
                    obs_wdata    = mem_wdata;
                    obs_unstable = 1'b0;
                    if (lat_q.size() > 0) begin
                        mm_lat  = lat_q.pop_front();
                        mm_data = dat_q.pop_front();
                    end else begin
                        mm_lat  = NEVER;
                        mm_data = '0;
                    end
                end else if (mar_out !== obs_addr || mem_rw !== obs_rw || mem_wdata !== obs_wdata) begin
                    obs_unstable = 1'b1;
                end
                mm_n++;
                obs_waits = mm_n;
                mfc       = (mm_n == mm_lat);
                mem_rdata = mfc ? mm_data : 16'($urandom);
            end else begin
                mm_busy   = 1'b0;
                mfc       = 1'($urandom_range(0, 1));
                mem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: every ack pops one expected transaction and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev_en = 1'b0;
            end else begin
                if (err && ack == 2'b00) begin
                    checks++; errors++;
                    $display("FAIL err_without_ack: err=1 ack=00 (cycle %0d)", cyc);
                end
                if (ack != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ack: got ack=%b with nothing outstanding (cycle %0d)", ack, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_id", ack, (e.id == 0) ? 2'b01 : 2'b10);
                        chk("err", err, e.err);
                        chk("rdata", rdata, e.rdata);
                        chk("mar_out", obs_addr, e.addr);
                        chk("mem_rw", obs_rw, e.rw);
                        chk("mem_wdata", obs_wdata, e.wdata);
                        chk("wait_cycles", obs_waits, e.waits);
                        chk("ack_cycle", cyc, e.ack_cyc);
                        chk("ack_follows_wait", {mon_prev_en, mem_en}, 2'b10);
                        chk("bus_stable", obs_unstable, 1'b0);
                    end
                end
                mon_prev_en = mem_en;
            end
        end
    end

    // Runs the queued transactions of both requesters as one round. The
    // expected grant order follows round robin over the pending counts; each
    // transaction spans IDLE + SETUP + waits + DONE cycles.
    task automatic run_round(input int gap);
        int   c0, c1, i0, i1, p, g, t, w, done, budget;
        txn_t tx;
        exp_t e;
        repeat (gap + 1) @(negedge clk);
        c0 = pq0.size(); c1 = pq1.size();
        p = model_ptr; t = cyc; i0 = 0; i1 = 0;
        while (i0 < c0 || i1 < c1) begin
            if (p == 0) g = (i0 < c0) ? 0 : 1;
            else        g = (i1 < c1) ? 1 : 0;
            if (g == 0) begin tx = pq0[i0]; i0++; end
            else        begin tx = pq1[i1]; i1++; end
            w = (tx.lat <= TIMEOUT) ? tx.lat : TIMEOUT;
            e.err = (tx.lat > TIMEOUT);
            if (e.err)      model_rdata = '0;
            else if (tx.rw) model_rdata = tx.mdata;
            e.id = g; e.rdata = model_rdata; e.rw = tx.rw; e.addr = tx.addr;
            e.wdata = tx.wdata; e.waits = w; e.ack_cyc = t + 2 + w;
            t = t + 3 + w;
            exp_q.push_back(e);
            lat_q.push_back(tx.lat);
            dat_q.push_back(tx.mdata);
            p = 1 - g;
        end
        model_ptr = p;

        if (c0 > 0) begin load(0, pq0[0]); req[0] = 1'b1; end
        if (c1 > 0) begin load(1, pq1[0]); req[1] = 1'b1; end
        i0 = 0; i1 = 0; done = 0; budget = 0;
        while (done < c0 + c1) begin
            @(negedge clk);
            budget++;
            if (budget > ROUND_BUDGET) begin
                checks++; errors++;
                $display("FAIL round_timeout: %0d of %0d acks after %0d cycles", done, c0 + c1, ROUND_BUDGET);
                hung = 1'b1;
                req  = 2'b00;
                break;
            end
            if (ack[0] && i0 < c0) begin
                i0++; done++;
                if (i0 < c0) load(0, pq0[i0]); else req[0] = 1'b0;
            end
            if (ack[1] && i1 < c1) begin
                i1++; done++;
                if (i1 < c1) load(1, pq1[i1]); else req[1] = 1'b0;
            end
        end
        pq0.delete();
        pq1.delete();
    endtask

    initial begin
        int n0, n1, budget;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", ack, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_mar_out", mar_out, 16'h0000);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_rw", mem_rw, 1'b0);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        reset = 1'b0;

        // reset pulse in the middle of WAIT: enable drops at once, no ack
        @(negedge clk);
        rw[0] = 1'b1; addr[15:0] = 16'h0055; wdata[15:0] = 16'h0066; req[0] = 1'b1;
        budget = 0;
        while (!mem_en && budget < 10) begin @(negedge clk); budget++; end
        repeat (3) @(negedge clk);
        chk("en_before_reset", mem_en, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_mem_en", mem_en, 1'b0);
        chk("async_reset_ack", ack, 2'b00);
        chk("async_reset_mar_out", mar_out, 16'h0000);
        @(negedge clk) req = 2'b00;
        @(negedge clk) reset = 1'b0;
        model_ptr = 0; model_rdata = '0;
        repeat (6) begin
            @(negedge clk);
            chk("no_ack_after_reset", ack, 2'b00);
        end

        // single read, MFC on the first WAIT cycle
        pq0.push_back(mk(1'b1, 16'h0010, 16'h0000, 16'hBEEF, 1));
        run_round(0);
        // single write from requester 1
        pq1.push_back(mk(1'b0, 16'h0200, 16'h1234, 16'h5A5A, 1));
        run_round(1);
        // both requesting continuously: grants alternate
        repeat (2) begin
            pq0.push_back(mk(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 1));
            pq1.push_back(mk(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 1));
        end
        run_round(0);
        // memory never answers: full timeout, err, rdata forced to zero
        pq0.push_back(mk(1'b1, 16'h0040, 16'h0000, 16'h7777, NEVER));
        run_round(0);
        // MFC on the very edge of the timeout: data captured, no err
        pq0.push_back(mk(1'b1, 16'h0041, 16'h0000, 16'hCAFE, TIMEOUT));
        run_round(2);

        // randomized rounds
        for (int r = 0; r < 60 && !hung; r++) begin
            n0 = int'($urandom_range(0, 3));
            n1 = int'($urandom_range(0, 3));
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) pq0.push_back(rand_txn());
            for (int k = 0; k < n1; k++) pq1.push_back(rand_txn());
            run_round(int'($urandom_range(0, 2)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
